// File: rtl/sam6883.sv
// ---------------------------------------------------------------------------
// sam6883 - synchronous address multiplexer for the CoCo2 core (MC6883 style)
//
// One block replaces the fixed E/Q divider, the hard-wired chip-select decode
// and the VDG-internal address generator:
//   * programmable 6809 E/Q clock phases (normal or double rate)
//   * map-type / page aware CPU memory decode and RAM address masking
//   * the $FFC0-$FFDF set/clear control register file
//   * mode dependent video address counter for the dual-port RAM B side
//
// Parameters
//   QUARTER : clk cycles per E/Q quarter phase at normal rate (even, >= 2)
//   VA_W    : width of the RAM address outputs
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   cpu_addr   in   CPU address
//   cpu_rw     in   1 = read, 0 = write
//   e, q       out  6809 E and Q clocks (registered)
//   e_fall     out  one-clk pulse on the last clk cycle of E high
//   sel        out  device select (0 RAM .. 6 $FF40 I/O, 7 none)
//   cpu_ram_a  out  masked / paged CPU RAM address (combinational)
//   vdg_fs     in   frame-start pulse
//   vdg_hs     in   end-of-line pulse
//   vdg_fetch  in   byte-consumed pulse
//   vid_a      out  video RAM address
//   ctrl       out  control register file contents
// ---------------------------------------------------------------------------
module sam6883 #(
  parameter int QUARTER = 16,
  parameter int VA_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     cpu_addr,
  input  logic            cpu_rw,
  output logic            e,
  output logic            q,
  output logic            e_fall,
  output logic [2:0]      sel,
  output logic [VA_W-1:0] cpu_ram_a,
  input  logic            vdg_fs,
  input  logic            vdg_hs,
  input  logic            vdg_fetch,
  output logic [VA_W-1:0] vid_a,
  output logic [15:0]     ctrl
);

  localparam int PH_W = $clog2(4 * QUARTER);

  // Phase thresholds for the normal rate (N_*) and the double rate (F_*).
  localparam logic [PH_W-1:0] N_QT   = PH_W'(QUARTER);
  localparam logic [PH_W-1:0] N_HALF = PH_W'(2 * QUARTER);
  localparam logic [PH_W-1:0] N_3QT  = PH_W'(3 * QUARTER);
  localparam logic [PH_W-1:0] N_EF   = PH_W'(3 * QUARTER - 1);
  localparam logic [PH_W-1:0] N_LAST = PH_W'(4 * QUARTER - 1);
  localparam logic [PH_W-1:0] F_QT   = PH_W'(QUARTER / 2);
  localparam logic [PH_W-1:0] F_HALF = PH_W'(2 * (QUARTER / 2));
  localparam logic [PH_W-1:0] F_3QT  = PH_W'(3 * (QUARTER / 2));
  localparam logic [PH_W-1:0] F_EF   = PH_W'(3 * (QUARTER / 2) - 1);
  localparam logic [PH_W-1:0] F_LAST = PH_W'(4 * (QUARTER / 2) - 1);

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // RAM size mask selected by M1:0; M >= 2 exposes the full 64K (and P1).
  function automatic logic [VA_W-1:0] mem_mask(input logic [VA_W-1:0] a,
                                               input logic [1:0]      m);
    logic [VA_W-1:0] k;
    case (m)
      2'd0:    k = VA_W'(16'h0FFF);
      2'd1:    k = VA_W'(16'h3FFF);
      default: k = VA_W'(16'hFFFF);
    endcase
    return a & k;
  endfunction

  // Device select from address and map type.
  function automatic logic [2:0] decode_sel(input logic [15:0] a,
                                            input logic        ty);
    logic [2:0] s;
    s = 3'd7;
    if (!a[15]) begin
      s = 3'd0;
    end else if (a[15:4] == 12'hFFF) begin
      // Interrupt vectors always come from the $A000 ROM, even in map type 1.
      s = 3'd2;
    end else if (a[15:8] != 8'hFF) begin
      if (ty)                     s = 3'd0;
      else if (a[14:13] == 2'b00) s = 3'd1;
      else if (a[14:13] == 2'b01) s = 3'd2;
      else                        s = 3'd3;
    end else begin
      case (a[7:5])
        3'b000:  s = 3'd4;
        3'b001:  s = 3'd5;
        3'b010:  s = 3'd6;
        default: s = 3'd7;
      endcase
    end
    return s;
  endfunction

  // Number of times each scan line is displayed, indexed by V2:0.
  function automatic logic [3:0] rep_count(input logic [2:0] v);
    logic [3:0] r;
    case (v)
      3'd0:       r = 4'd12;
      3'd1, 3'd2: r = 4'd3;
      3'd3, 3'd4: r = 4'd2;
      default:    r = 4'd1;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Control register fields
  // -------------------------------------------------------------------------
  logic [15:0] ctrl_q, ctrl_d;
  logic [2:0]  f_v;
  logic [6:0]  f_f;
  logic        f_p1;
  logic [1:0]  f_r;
  logic [1:0]  f_m;
  logic        f_ty;

  assign f_v  = ctrl_q[2:0];
  assign f_f  = ctrl_q[9:3];
  assign f_p1 = ctrl_q[10];
  assign f_r  = ctrl_q[12:11];
  assign f_m  = ctrl_q[14:13];
  assign f_ty = ctrl_q[15];

  // -------------------------------------------------------------------------
  // Phase counter and E/Q generation
  // -------------------------------------------------------------------------
  logic [PH_W-1:0] ph_q, ph_d;
  logic            fast_q, fast_d;
  logic            e_q, e_d;
  logic            q_q, q_d;
  logic            e_fall_q, e_fall_d;
  logic [PH_W-1:0] th_qt, th_half, th_3qt, th_ef, th_last;

  // The rate in force is latched only at the wrap, so an E cycle is never
  // stretched or shortened part way through.
  always_comb begin
    th_qt   = fast_q ? F_QT   : N_QT;
    th_half = fast_q ? F_HALF : N_HALF;
    th_3qt  = fast_q ? F_3QT  : N_3QT;
    th_ef   = fast_q ? F_EF   : N_EF;
    th_last = fast_q ? F_LAST : N_LAST;
  end

  always_comb begin
    q_d      = (ph_q < th_half);
    e_d      = (ph_q >= th_qt) && (ph_q < th_3qt);
    e_fall_d = (ph_q == th_ef);
    if (ph_q == th_last) begin
      ph_d   = '0;
      fast_d = (f_r != 2'b00);
    end else begin
      ph_d   = ph_q + 1'b1;
      fast_d = fast_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q     <= '0;
      fast_q   <= 1'b0;
      e_q      <= 1'b0;
      q_q      <= 1'b0;
      e_fall_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      fast_q   <= fast_d;
      e_q      <= e_d;
      q_q      <= q_d;
      e_fall_q <= e_fall_d;
    end
  end

  assign e      = e_q;
  assign q      = q_q;
  assign e_fall = e_fall_q;

  // -------------------------------------------------------------------------
  // Control register file: $FFC0-$FFDF, even address clears, odd sets.
  // The write lands at the end of the E-high window, when the 6809 has the
  // address and R/W stable.
  // -------------------------------------------------------------------------
  logic ctrl_hit;
  assign ctrl_hit = (cpu_addr[15:5] == 11'h7FE);

  always_comb begin
    ctrl_d = ctrl_q;
    if (e_fall_q && !cpu_rw && ctrl_hit) begin
      ctrl_d[cpu_addr[4:1]] = cpu_addr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl_d;
  end

  assign ctrl = ctrl_q;

  // -------------------------------------------------------------------------
  // CPU decode (combinational)
  // -------------------------------------------------------------------------
  logic [15:0] cpu_raw;

  always_comb begin
    sel       = decode_sel(cpu_addr, f_ty);
    cpu_raw   = f_ty ? cpu_addr : {f_p1, cpu_addr[14:0]};
    cpu_ram_a = mem_mask(VA_W'(cpu_raw), f_m);
  end

  // -------------------------------------------------------------------------
  // Video address counter
  // -------------------------------------------------------------------------
  logic [VA_W-1:0] vid_a_q, vid_a_d;
  logic [VA_W-1:0] ls_q, ls_d;
  logic [3:0]      rep_q, rep_d;
  logic [VA_W-1:0] vid_base;
  logic [VA_W-1:0] line_bytes;
  logic [VA_W-1:0] next_line;
  logic [3:0]      rep_last;

  // V/F are sampled only when the event that uses them arrives, so a mode
  // change mid-frame takes effect at the next hs (geometry) or fs (base).
  always_comb begin
    vid_base   = mem_mask(VA_W'({f_f, 9'b0}), f_m);
    line_bytes = (f_v == 3'd1 || f_v == 3'd3 || f_v == 3'd5) ?
                 VA_W'(16) : VA_W'(32);
    rep_last   = rep_count(f_v) - 4'd1;
    next_line  = mem_mask(ls_q + line_bytes, f_m);
  end

  // fs > hs > fetch; a lower-priority pulse in the same cycle is dropped.
  always_comb begin
    vid_a_d = vid_a_q;
    ls_d    = ls_q;
    rep_d   = rep_q;
    if (vdg_fs) begin
      vid_a_d = vid_base;
      ls_d    = vid_base;
      rep_d   = '0;
    end else if (vdg_hs) begin
      if (rep_q == rep_last) begin
        rep_d   = '0;
        ls_d    = next_line;
        vid_a_d = next_line;
      end else begin
        rep_d   = rep_q + 4'd1;
        vid_a_d = ls_q;
      end
    end else if (vdg_fetch) begin
      vid_a_d = mem_mask(vid_a_q + VA_W'(1), f_m);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_a_q <= '0;
      ls_q    <= '0;
      rep_q   <= '0;
    end else begin
      vid_a_q <= vid_a_d;
      ls_q    <= ls_d;
      rep_q   <= rep_d;
    end
  end

  assign vid_a = vid_a_q;

endmodule

// File: tb/tb_sam6883.sv
// ---------------------------------------------------------------------------
// tb_sam6883 - self-checking bench for sam6883 (QUARTER = 16, VA_W = 16).
// Directed edge timing, a decode vector table, directed video sequences,
// randomized decode/video traffic against a behavioural model, rate switch
// and mid-cycle reset.
// ---------------------------------------------------------------------------
module tb_sam6883;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        e, q, e_fall;
  logic [2:0]  sel;
  logic [15:0] cpu_ram_a;
  logic        vdg_fs, vdg_hs, vdg_fetch;
  logic [15:0] vid_a;
  logic [15:0] ctrl;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  // Bench-side models
  logic [15:0] ctrl_m;
  int          m_va, m_ls, m_rep;

  sam6883 #(.QUARTER(16), .VA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_rw    (cpu_rw),
    .e         (e),
    .q         (q),
    .e_fall    (e_fall),
    .sel       (sel),
    .cpu_ram_a (cpu_ram_a),
    .vdg_fs    (vdg_fs),
    .vdg_hs    (vdg_hs),
    .vdg_fetch (vdg_fetch),
    .vid_a     (vid_a),
    .ctrl      (ctrl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] ctrl_v;
    logic [15:0] addr;
    logic [2:0]  exp_sel;
    logic [15:0] exp_ram;
  } dec_vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return q;
      1:       return e;
      2:       return e_fall;
      default: return ~e;
    endcase
  endfunction

  // Waits for a rising edge of the selected signal (3 = falling edge of e).
  task automatic wait_rise(input int w, output int unsigned t);
    logic prev;
    prev = sig(w);
    t = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!prev && sig(w)) begin
        t = cyc;
        return;
      end
      prev = sig(w);
    end
    n_checks++;
    n_fail++;
    $display("FAIL timeout waiting for edge of signal %0d", w);
  endtask

  // Presents a control-register access and holds it through one e_fall.
  task automatic write_bit(input int idx, input logic val, input logic rw);
    cpu_addr = 16'hFFC0 | 16'(idx << 1) | {15'b0, val};
    cpu_rw   = rw;
    for (int i = 0; i < 300; i++) begin
      if (e_fall) begin
        tick();
        cpu_rw   = 1'b1;
        cpu_addr = 16'h0000;
        if (!rw) ctrl_m[idx] = val;
        return;
      end
      tick();
    end
    cpu_rw   = 1'b1;
    cpu_addr = 16'h0000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout waiting for e_fall (write bit %0d)", idx);
  endtask

  task automatic set_ctrl(input logic [15:0] target);
    for (int i = 0; i < 16; i++)
      if (ctrl_m[i] != target[i]) write_bit(i, target[i], 1'b0);
    check("ctrl after set", 32'(ctrl), 32'(target));
  endtask

  // ---- reference decode, written from the address map with plain ranges ---
  function automatic int ref_sel(input int a, input logic [15:0] c);
    if (a < 'h8000) return 0;
    if (a >= 'hFFF0) return 2;
    if (a <= 'hFEFF) begin
      if (c[15]) return 0;
      if (a < 'hA000) return 1;
      if (a < 'hC000) return 2;
      return 3;
    end
    if (a < 'hFF20) return 4;
    if (a < 'hFF40) return 5;
    if (a < 'hFF60) return 6;
    return 7;
  endfunction

  function automatic int ram_span(input logic [1:0] m);
    if (m == 2'd0) return 4096;
    if (m == 2'd1) return 16384;
    return 65536;
  endfunction

  function automatic int ref_ram(input int a, input logic [15:0] c);
    int r;
    if (c[15]) r = a;
    else       r = (c[10] ? 32768 : 0) + (a % 32768);
    return r % ram_span(c[14:13]);
  endfunction

  function automatic int rep_of(input logic [2:0] v);
    int t[8] = '{12, 3, 3, 2, 2, 1, 1, 1};
    return t[v];
  endfunction

  // Applies one cycle of video pulses and advances the video model.
  task automatic vpulse(input logic f, input logic h, input logic x);
    int span, bytes;
    vdg_fs = f; vdg_hs = h; vdg_fetch = x;
    tick();
    vdg_fs = 1'b0; vdg_hs = 1'b0; vdg_fetch = 1'b0;
    span  = ram_span(ctrl_m[14:13]);
    bytes = (ctrl_m[2:0] inside {3'd1, 3'd3, 3'd5}) ? 16 : 32;
    if (f) begin
      m_ls  = (int'(ctrl_m[9:3]) * 512) % span;
      m_va  = m_ls;
      m_rep = 0;
    end else if (h) begin
      if (m_rep == rep_of(ctrl_m[2:0]) - 1) begin
        m_rep = 0;
        m_ls  = (m_ls + bytes) % span;
        m_va  = m_ls;
      end else begin
        m_rep = (m_rep + 1) % 16;
        m_va  = m_ls;
      end
    end else if (x) begin
      m_va = (m_va + 1) % span;
    end
  endtask

  initial begin
    dec_vec_t    vecs[15];
    int unsigned t0, t1, t2, t3;
    int          a;
    logic [15:0] tgt;

    vecs[0]  = '{16'h0000, 16'h7FFF, 3'd0, 16'h0FFF};
    vecs[1]  = '{16'h0000, 16'h9000, 3'd1, 16'h0000};
    vecs[2]  = '{16'h0000, 16'hBFFF, 3'd2, 16'h0FFF};
    vecs[3]  = '{16'h0000, 16'hFEFF, 3'd3, 16'h0EFF};
    vecs[4]  = '{16'h0000, 16'hFF00, 3'd4, 16'h0F00};
    vecs[5]  = '{16'h0000, 16'hFF3F, 3'd5, 16'h0F3F};
    vecs[6]  = '{16'h0000, 16'hFF40, 3'd6, 16'h0F40};
    vecs[7]  = '{16'h0000, 16'hFFC0, 3'd7, 16'h0FC0};
    vecs[8]  = '{16'h0000, 16'hFFFE, 3'd2, 16'h0FFE};
    vecs[9]  = '{16'h0000, 16'hFF60, 3'd7, 16'h0F60};
    vecs[10] = '{16'h8000, 16'hC000, 3'd0, 16'h0000};
    vecs[11] = '{16'h8000, 16'hFFFE, 3'd2, 16'h0FFE};
    vecs[12] = '{16'h4400, 16'h1234, 3'd0, 16'h9234};
    vecs[13] = '{16'h0400, 16'h1234, 3'd0, 16'h0234};
    vecs[14] = '{16'h2000, 16'h5678, 3'd0, 16'h1678};

    reset = 1'b1; cpu_addr = 16'h0000; cpu_rw = 1'b1;
    vdg_fs = 1'b0; vdg_hs = 1'b0; vdg_fetch = 1'b0;
    ctrl_m = 16'h0000; m_va = 0; m_ls = 0; m_rep = 0;

    // ---------------- reset state and clock edges ----------------
    repeat (3) tick();
    check("reset e", 32'(e), 32'd0);
    check("reset q", 32'(q), 32'd0);
    check("reset e_fall", 32'(e_fall), 32'd0);
    check("reset ctrl", 32'(ctrl), 32'd0);
    check("reset vid_a", 32'(vid_a), 32'd0);
    reset = 1'b0;
    t0 = cyc;
    wait_rise(0, t1); check("first q rise clk", t1 - t0, 32'd1);
    wait_rise(1, t1); check("first e rise clk", t1 - t0, 32'd17);
    wait_rise(2, t1); check("first e_fall clk", t1 - t0, 32'd48);
    wait_rise(3, t1); check("first e fall clk", t1 - t0, 32'd49);
    wait_rise(1, t1); check("second e rise clk", t1 - t0, 32'd81);

    // ---------------- register file writes ----------------
    write_bit(3, 1'b1, 1'b0);
    check("ctrl after FFC7", 32'(ctrl), 32'h0008);
    write_bit(4, 1'b1, 1'b0);
    write_bit(3, 1'b0, 1'b0);
    check("ctrl after FFC7/FFC9/FFC6", 32'(ctrl), 32'h0010);
    write_bit(3, 1'b1, 1'b1);
    check("ctrl after read of FFC7", 32'(ctrl), 32'h0010);

    // ---------------- decode vector table ----------------
    foreach (vecs[i]) begin
      set_ctrl(vecs[i].ctrl_v);
      cpu_addr = vecs[i].addr;
      #1;
      check($sformatf("sel @%h ctrl %h", vecs[i].addr, vecs[i].ctrl_v),
            32'(sel), 32'(vecs[i].exp_sel));
      check($sformatf("ram_a @%h ctrl %h", vecs[i].addr, vecs[i].ctrl_v),
            32'(cpu_ram_a), 32'(vecs[i].exp_ram));
    end
    cpu_addr = 16'h0000;

    // ---------------- randomized decode ----------------
    for (int k = 0; k < 6; k++) begin
      tgt = 16'h0000;
      tgt[15]    = 1'($urandom_range(0, 1));
      tgt[14:13] = 2'($urandom_range(0, 3));
      tgt[10]    = 1'($urandom_range(0, 1));
      set_ctrl(tgt);
      for (int j = 0; j < 100; j++) begin
        a = int'($urandom_range(0, 65535));
        if (j % 4 == 0) a = int'($urandom_range(16'hFF00, 16'hFFFF));
        cpu_addr = 16'(a);
        #1;
        check($sformatf("rand sel @%h", a), 32'(sel), 32'(ref_sel(a, ctrl_m)));
        check($sformatf("rand ram_a @%h", a), 32'(cpu_ram_a),
              32'(ref_ram(a, ctrl_m)));
      end
    end
    cpu_addr = 16'h0000;

    // ---------------- video V=0, F=2, M=2 ----------------
    set_ctrl(16'h4010);
    vpulse(1, 0, 0); check("vid fs base", 32'(vid_a), 32'h0400);
    repeat (32) vpulse(0, 0, 1);
    check("vid 32 fetches", 32'(vid_a), 32'h0420);
    for (int i = 0; i < 11; i++) begin
      vpulse(0, 1, 0);
      check($sformatf("vid hs repeat %0d", i + 1), 32'(vid_a), 32'h0400);
    end
    vpulse(0, 1, 0); check("vid 12th hs", 32'(vid_a), 32'h0420);
    vpulse(1, 1, 0); check("vid fs+hs", 32'(vid_a), 32'h0400);
    vpulse(0, 1, 1); check("vid hs+fetch", 32'(vid_a), 32'h0400);
    vpulse(1, 0, 1); check("vid fs+fetch", 32'(vid_a), 32'h0400);

    // ---------------- video V=1 ----------------
    set_ctrl(16'h4011);
    vpulse(1, 0, 0);
    vpulse(0, 1, 0); check("V1 hs rep0", 32'(vid_a), 32'h0400);
    vpulse(0, 1, 0); check("V1 hs rep1", 32'(vid_a), 32'h0400);
    vpulse(0, 1, 0); check("V1 hs rep2", 32'(vid_a), 32'h0410);

    // ---------------- video wrap M=1, F=127 ----------------
    set_ctrl(16'h23F8);
    vpulse(1, 0, 0); check("wrap base", 32'(vid_a), 32'h3E00);
    repeat (511) vpulse(0, 0, 1);
    check("wrap top", 32'(vid_a), 32'h3FFF);
    vpulse(0, 0, 1); check("wrap to zero", 32'(vid_a), 32'h0000);

    // ---------------- randomized video traffic ----------------
    for (int k = 0; k < 4; k++) begin
      tgt = 16'h0000;
      tgt[2:0]   = 3'($urandom_range(0, 7));
      tgt[9:3]   = 7'($urandom_range(0, 127));
      tgt[14:13] = 2'($urandom_range(0, 3));
      set_ctrl(tgt);
      for (int j = 0; j < 250; j++) begin
        vpulse(($urandom % 40) == 0, ($urandom % 6) == 0, ($urandom % 2) == 0);
        check($sformatf("rand vid_a k%0d j%0d", k, j), 32'(vid_a), 32'(m_va));
      end
    end

    // ---------------- rate switch ----------------
    set_ctrl(16'h0000);
    wait_rise(0, t0);
    write_bit(11, 1'b1, 1'b0);
    wait_rise(0, t1);
    wait_rise(0, t2);
    wait_rise(0, t3);
    check("period of cycle with R0 write", t1 - t0, 32'd64);
    check("first fast period", t2 - t1, 32'd32);
    check("second fast period", t3 - t2, 32'd32);
    wait_rise(1, t0);
    wait_rise(3, t1);
    check("fast e high width", t1 - t0, 32'd16);

    // ---------------- reset mid-cycle ----------------
    wait_rise(1, t0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ctrl_m = 16'h0000; m_va = 0; m_ls = 0; m_rep = 0;
    check("mid reset e", 32'(e), 32'd0);
    check("mid reset q", 32'(q), 32'd0);
    check("mid reset ctrl", 32'(ctrl), 32'd0);
    check("mid reset vid_a", 32'(vid_a), 32'd0);

    // A write pending on the e_fall cycle is lost if reset lands on it.
    cpu_addr = 16'hFFCB;
    cpu_rw   = 1'b0;
    for (int i = 0; i < 300 && !e_fall; i++) tick();
    check("e_fall reached for pending write", 32'(e_fall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_rw = 1'b1;
    cpu_addr = 16'h0000;
    tick();
    check("pending write discarded", 32'(ctrl), 32'd0);
    wait_rise(0, t0);
    wait_rise(0, t1);
    check("period after reset", t1 - t0, 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
